// File: rtl/sensor_link_scheduler.sv
// sensor_link_scheduler: round-robin arbiter in front of one serial sensor link.
// Each grant captures the winner's sample and sends a tagged frame LSB first:
// preamble 3'b101, channel id, data byte, even parity. An idle gap follows each frame.
module sensor_link_scheduler #(
    parameter int N_CH = 4,
    parameter int CH_W = 2,
    parameter int GAP  = 4
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic [N_CH-1:0]     req_i,
    input  logic [8*N_CH-1:0]   data_in_i,
    output logic [N_CH-1:0]     ack_o,
    output logic                data_out_o,
    output logic                data_valid_o,
    output logic                busy_o,
    output logic [CH_W-1:0]     grant_id_o
);
    localparam int FRAME_W = 3 + CH_W + 8 + 1;
    localparam int CNT_W   = $clog2(FRAME_W + 1);

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAP} state_t;

    state_t             state_q;
    logic [FRAME_W-1:0] frame_q;
    logic [CNT_W-1:0]   bit_cnt_q;
    logic [7:0]         gap_cnt_q;
    logic [CH_W-1:0]    last_q;
    logic [CH_W-1:0]    grant_id_q;
    logic [N_CH-1:0]    ack_q;
    logic               data_out_q;
    logic               data_valid_q;
    logic               busy_q;

    logic               found_d;
    logic [CH_W-1:0]    winner_d;
    logic [7:0]         sample_d;
    logic [FRAME_W-1:0] frame_d;
    int                 idx;

    // Round-robin pick: first requester after the last winner, wrapping.
    always_comb begin
        found_d  = 1'b0;
        winner_d = '0;
        idx      = 0;
        for (int i = 1; i <= N_CH; i++) begin
            idx = (int'(last_q) + i) % N_CH;
            if (!found_d && req_i[idx]) begin
                found_d  = 1'b1;
                winner_d = CH_W'(idx);
            end
        end
        sample_d = data_in_i[int'(winner_d)*8 +: 8];
        frame_d  = {^sample_d, sample_d, winner_d, 3'b101};
    end

    // Frame sequencer: IDLE grants and presents bit 0, SHIFT walks the frame, GAP idles.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q      <= S_IDLE;
            frame_q      <= '0;
            bit_cnt_q    <= '0;
            gap_cnt_q    <= '0;
            last_q       <= CH_W'(N_CH - 1);
            grant_id_q   <= '0;
            ack_q        <= '0;
            data_out_q   <= 1'b0;
            data_valid_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            ack_q <= '0;
            case (state_q)
                S_IDLE: begin
                    if (found_d) begin
                        // Bit 0 goes out with the ack; the register keeps the rest.
                        frame_q          <= frame_d >> 1;
                        data_out_q       <= frame_d[0];
                        data_valid_q     <= 1'b1;
                        busy_q           <= 1'b1;
                        ack_q[winner_d]  <= 1'b1;
                        grant_id_q       <= winner_d;
                        last_q           <= winner_d;
                        bit_cnt_q        <= CNT_W'(1);
                        state_q          <= S_SHIFT;
                    end else begin
                        data_out_q   <= 1'b0;
                        data_valid_q <= 1'b0;
                        busy_q       <= 1'b0;
                    end
                end
                S_SHIFT: begin
                    if (bit_cnt_q == CNT_W'(FRAME_W)) begin
                        data_out_q   <= 1'b0;
                        data_valid_q <= 1'b0;
                        if (GAP > 0) begin
                            gap_cnt_q <= 8'(GAP - 1);
                            busy_q    <= 1'b1;
                            state_q   <= S_GAP;
                        end else begin
                            busy_q  <= 1'b0;
                            state_q <= S_IDLE;
                        end
                    end else begin
                        data_out_q <= frame_q[0];
                        frame_q    <= frame_q >> 1;
                        bit_cnt_q  <= bit_cnt_q + CNT_W'(1);
                    end
                end
                S_GAP: begin
                    if (gap_cnt_q == 8'd0) begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else begin
                        gap_cnt_q <= gap_cnt_q - 8'd1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign ack_o        = ack_q;
    assign data_out_o   = data_out_q;
    assign data_valid_o = data_valid_q;
    assign busy_o       = busy_q;
    assign grant_id_o   = grant_id_q;
endmodule

// File: doc/sensor_link_scheduler.md
Name: sensor_link_scheduler

Overview:
- Shares one serial sensor link between N_CH sample sources.
- A round-robin arbiter grants one requester per frame and captures its 8-bit sample. It builds a tagged frame (preamble, channel id, data, parity) and shifts it out LSB first with data_valid.
- A programmable idle gap follows each frame. The block sits between the per-sensor sample registers and the serial link driver.

Parameters:
- N_CH, 4, number of requesting channels (2..8).
- CH_W, 2, channel-id field width; must satisfy 2**CH_W >= N_CH.
- GAP, 4, idle cycles after each frame, data_valid low (0..255).
- FRAME_W, 3+CH_W+8+1 (=14 at defaults), derived frame length in bits; not overridable.

Ports:
- clk, input, 1: single clock, all logic on posedge.
- reset, input, 1: synchronous, active-high reset.
- req, input, N_CH: per-channel sample request; held high until the matching ack.
- data_in, input, 8*N_CH: channel k sample at data_in[8k+7:8k].
- ack, output, N_CH: one-cycle pulse to the granted channel when its sample is captured.
- data_out, output, 1: serial frame bit.
- data_valid, output, 1: high while data_out carries a frame bit.
- busy, output, 1: high in SHIFT and GAP states.
- grant_id, output, CH_W: channel of the current or last frame.

Behaviour:
- Reset (sync, active-high, overrides everything):
  - data_out=0, data_valid=0, ack=0, busy=0, grant_id=0.
  - State=IDLE, bit counter=0, gap counter=0.
  - RR pointer last=N_CH-1, so channel 0 has first priority.
- Reset asserted mid-frame aborts the frame. data_valid drops at the next edge, no partial frame resumes, and no ack is issued for the aborted capture if ack is not yet out.
- All outputs are registered.
- Frame layout (bit 0 sent first):
  - [2:0] = 3'b101
  - [2+CH_W:3] = channel id
  - [10+CH_W:3+CH_W] = data byte
  - [FRAME_W-1] = XOR of the 8 data bits (even parity)
- Arbitration:
  - Search order starts at last+1 mod N_CH and wraps.
  - The first channel with req=1 wins and last becomes the winner.
  - Channels with req=0 are skipped. A lone requester is always granted.
- IDLE:
  - data_valid=0, busy=0.
  - If any req bit is set at an edge: latch the winner's data_in into the frame register, set grant_id, go to SHIFT.
  - Otherwise stay in IDLE.
- SHIFT (FRAME_W cycles):
  - First SHIFT cycle: data_out=frame[0], data_valid=1, busy=1, ack[winner]=1 for exactly this cycle.
  - Each following cycle presents the next bit.
  - After bit FRAME_W-1: go to GAP if GAP>0, else IDLE.
- GAP (GAP cycles): data_valid=0, data_out=0, busy=1, then IDLE.
- Latency and throughput:
  - A req seen at IDLE edge t gives ack and bit 0 in cycle t+1.
  - Minimum spacing between frame starts is FRAME_W+GAP+1 cycles.
- Requester rules:
  - data_in must be stable in the cycle its req is first sampled in IDLE.
  - req and data_in changes during SHIFT/GAP are ignored.
  - req still high after ack counts as a new request at the next IDLE.
- Simultaneous events:
  - New req arriving during SHIFT/GAP waits; no drop, no preemption.
  - req falling before grant means no service and no ack.
- ack and data_valid never assert in IDLE or GAP.

Test Plan:
1. Single request: reset, then req=4'b0100, data_in ch2=8'hA5.
   - ack[2] pulses one cycle; grant_id=2.
   - 14 valid bits in order 1,0,1,0,1,1,0,1,0,0,1,0,1,0.
   - Then 4 cycles with data_valid=0, then idle.
2. Round-robin fairness: req=4'b1111 held continuously, data ch k = 8'h10+k.
   - Grant order 0,1,2,3,0.
   - Frame starts exactly 19 cycles apart.
   - Each ack is a single-cycle pulse.
3. Skip and wrap: last=2, req=4'b0011.
   - Grant goes to channel 0 (wraps past 3), then channel 1.
   - Channel 3 is never acked.
4. Parity: ch1 data 8'hFF gives parity bit 0; 8'h01 gives parity bit 1.
   - Preamble bits [2:0]=101 present in both frames.
5. Reset mid-frame: assert reset during bit 6 of a frame.
   - Next edge: data_valid=0, busy=0, ack=0.
   - After release, req=4'b0001 restarts cleanly from channel 0 with a full 14-bit frame.
6. Late/withdrawn request: ch3 raises req during GAP and ch1 pulses req for 1 cycle during SHIFT.
   - Ch3 is served at the next IDLE.
   - Ch1 gets no ack and no frame.
